// File: rtl/imem_fetch_resp.sv
// Instruction-memory responder: grants PC fetches, waits WAIT_CYCLES, then returns one
// instruction per request; a load port fills the array. Bad fetches return NOP with err_o.
module imem_fetch_resp #(
  parameter int          DEPTH_WORDS = 2048,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] instr_o,
  output logic        err_o,
  output logic        busy_o,
  input  logic        ld_we_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i,
  output logic [1:0]  dbg_state_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q;
  logic [31:0]   instr_q;
  logic          err_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          enter_resp;
  logic [31:0]   rd_addr;
  logic          rd_err;
  logic [AW-1:0] rd_idx;
  logic          ld_ok;

  // Handshake: a request is accepted in any cycle where req_i and gnt_o are both high;
  // gnt_o is only offered from IDLE or RESP, and rvalid_o pulses once per accepted request.
  always_comb begin
    gnt_o      = req_i && ((state_q == S_IDLE) || (state_q == S_RESP));
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (gnt_o) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the read happens on the grant edge, before addr_q is loaded.
  assign rd_addr = (state_q == S_WAIT) ? addr_q : addr_i;
  assign rd_err  = (rd_addr[1:0] != 2'b00) || (rd_addr[31:AW+2] != '0);
  assign rd_idx  = rd_addr[AW+1:2];
  assign ld_ok   = ld_we_i && (ld_addr_i[1:0] == 2'b00) && (ld_addr_i[31:AW+2] == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      instr_q <= NOP_INSTR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (gnt_o) addr_q <= addr_i;
      if (enter_resp) begin
        if (rd_err) begin
          instr_q <= NOP_INSTR;
          err_q   <= 1'b1;
        end else begin
          instr_q <= mem[rd_idx];
          err_q   <= 1'b0;
        end
      end
    end
  end

  // Non-blocking update gives read-before-write when a load hits the word being fetched.
  always_ff @(posedge clk_i) begin
    if (ld_ok) mem[ld_addr_i[AW+1:2]] <= ld_data_i;
  end

  assign rvalid_o    = (state_q == S_RESP);
  assign busy_o      = (state_q != S_IDLE);
  assign instr_o     = instr_q;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule
